// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM capture types and defaults
package pwm_pkg;

  localparam int DEFAULT_PWM_PERIOD = 256;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

endpackage

// File: rtl/synchronizer.sv
// rtl/synchronizer.sv - 2-flop single-bit synchronizer, async active-low reset
module synchronizer (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM duty-cycle capture with frame-length lock and timeout
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int PERIOD = DEFAULT_PWM_PERIOD
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       sig_in,
  input  logic       en_in,
  output logic [7:0] dc_out,
  output logic       valid_out,
  output logic       locked_out,
  output logic       err_out
);

  localparam int CW = $clog2(2 * PERIOD) + 1;
  localparam logic [CW-1:0] PERIOD_C       = CW'(PERIOD);
  localparam logic [CW-1:0] TIMEOUT_LAST_C = CW'(2 * PERIOD - 1);
  localparam logic [CW-1:0] ONE_C          = CW'(1);

  logic s;
  logic s_prev;
  logic rise;

  state_t state, state_nxt;

  logic [CW-1:0] period_cnt, period_nxt;
  logic [CW-1:0] high_cnt, high_nxt;
  logic [CW-1:0] timeout_cnt, timeout_nxt;
  logic [7:0]    dc_nxt;
  logic          valid_nxt, locked_nxt, err_nxt;

  synchronizer u_sync (
    .clk   (clk_in),
    .rst_n (rst_in),
    .d     (sig_in),
    .q     (s)
  );

  assign rise = s & ~s_prev;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    period_nxt  = period_cnt;
    high_nxt    = high_cnt;
    timeout_nxt = timeout_cnt;
    dc_nxt      = dc_out;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;
    locked_nxt  = locked_out;

    if (!en_in) begin
      state_nxt   = IDLE;
      period_nxt  = '0;
      high_nxt    = '0;
      timeout_nxt = '0;
      locked_nxt  = 1'b0;
    end else if (rise) begin
      // A rise always closes the open frame, even when the timeout is due.
      state_nxt   = MEASURE;
      period_nxt  = ONE_C;
      high_nxt    = ONE_C;
      timeout_nxt = '0;
      if (state == MEASURE) begin
        if (period_cnt == PERIOD_C) begin
          dc_nxt     = 8'(high_cnt);
          valid_nxt  = 1'b1;
          locked_nxt = 1'b1;
        end else begin
          err_nxt    = 1'b1;
          locked_nxt = 1'b0;
        end
      end
    end else if (timeout_cnt == TIMEOUT_LAST_C) begin
      state_nxt   = IDLE;
      timeout_nxt = '0;
      dc_nxt      = {8{s}};
      valid_nxt   = 1'b1;
      locked_nxt  = 1'b0;
    end else begin
      timeout_nxt = timeout_cnt + ONE_C;
      if (state == MEASURE) begin
        period_nxt = period_cnt + ONE_C;
        high_nxt   = high_cnt + {{(CW-1){1'b0}}, s};
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      s_prev      <= 1'b0;
      period_cnt  <= '0;
      high_cnt    <= '0;
      timeout_cnt <= '0;
      dc_out      <= '0;
      valid_out   <= 1'b0;
      locked_out  <= 1'b0;
      err_out     <= 1'b0;
    end else begin
      s_prev      <= s;
      period_cnt  <= period_nxt;
      high_cnt    <= high_nxt;
      timeout_cnt <= timeout_nxt;
      dc_out      <= dc_nxt;
      valid_out   <= valid_nxt;
      locked_out  <= locked_nxt;
      err_out     <= err_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture against a frame-level model
module tb_pwm_capture;

  localparam int P = 256;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic       sig_in;
  logic       en_in;
  logic [7:0] dc_out;
  logic       valid_out;
  logic       locked_out;
  logic       err_out;

  pwm_capture #(.PERIOD(P)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .sig_in     (sig_in),
    .en_in      (en_in),
    .dc_out     (dc_out),
    .valid_out  (valid_out),
    .locked_out (locked_out),
    .err_out    (err_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_fail   = 0;
  int vcnt     = 0;
  int ecnt     = 0;
  int v0, e0;
  int ph       = 0;

  // Model: sig_in samples reach the capture logic two edges late; a frame is
  // the list of samples from one rise up to the next.
  logic h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;
  bit   m_meas = 1'b0;
  bit   frame[$];
  int   n_edge = 0;
  int   t_ref  = 0;
  logic [7:0] exp_dc = 8'd0;
  logic exp_valid = 1'b0, exp_locked = 1'b0, exp_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    h0 = 1'b0; h1 = 1'b0; h2 = 1'b0;
    m_meas = 1'b0;
    frame.delete();
    exp_dc = 8'd0; exp_valid = 1'b0; exp_locked = 1'b0; exp_err = 1'b0;
    t_ref = n_edge;
  endtask

  task automatic model_edge();
    logic s, sp;
    int ones;
    if (!rst_in) begin
      model_reset();
    end else begin
      n_edge++;
      s = h1; sp = h2;
      h2 = h1; h1 = h0; h0 = sig_in;
      exp_valid = 1'b0;
      exp_err   = 1'b0;
      if (!en_in) begin
        m_meas = 1'b0;
        frame.delete();
        t_ref = n_edge;
        exp_locked = 1'b0;
      end else if (s && !sp) begin
        if (m_meas) begin
          if (frame.size() == P) begin
            ones = 0;
            foreach (frame[i]) ones += int'(frame[i]);
            exp_dc = 8'(ones);
            exp_valid = 1'b1;
            exp_locked = 1'b1;
          end else begin
            exp_err = 1'b1;
            exp_locked = 1'b0;
          end
        end
        m_meas = 1'b1;
        frame.delete();
        frame.push_back(1'b1);
        t_ref = n_edge;
      end else if (n_edge - t_ref == 2 * P) begin
        exp_dc = s ? 8'd255 : 8'd0;
        exp_valid = 1'b1;
        exp_locked = 1'b0;
        m_meas = 1'b0;
        frame.delete();
        t_ref = n_edge;
      end else if (m_meas) begin
        frame.push_back(s);
      end
    end
  endtask

  task automatic step(input logic v);
    sig_in = v;
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    chk("cyc_valid", valid_out, exp_valid);
    chk("cyc_err", err_out, exp_err);
    chk("cyc_locked", locked_out, exp_locked);
    chk("cyc_dc", dc_out, exp_dc);
    if (valid_out) vcnt++;
    if (err_out) ecnt++;
  endtask

  task automatic pwm(input int dc, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      step(ph < dc);
      ph = (ph + 1) % P;
    end
  endtask

  task automatic frame_raw(input int len, input int hi);
    for (int i = 0; i < len; i++) step(i < hi);
  endtask

  task automatic async_reset(input int ncyc);
    #2 rst_in = 1'b0;
    model_reset();
    #1;
    chk("rst_dc", dc_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_locked", locked_out, 0);
    chk("rst_err", err_out, 0);
    for (int i = 0; i < ncyc; i++) step(sig_in);
    rst_in = 1'b1;
  endtask

  initial begin
    int len, hi, lvl;
    rst_in = 1'b0;
    en_in  = 1'b1;
    sig_in = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0);
    chk("reset_dc", dc_out, 0);
    chk("reset_valid", valid_out, 0);
    chk("reset_locked", locked_out, 0);
    chk("reset_err", err_out, 0);
    rst_in = 1'b1;

    // dc=100 stream: valid from the second rise on
    ph = 0; v0 = vcnt; e0 = ecnt;
    pwm(100, 6 * P);
    chk("dc100_valids", vcnt - v0, 5);
    chk("dc100_errs", ecnt - e0, 0);
    chk("dc100_dc", dc_out, 100);
    chk("dc100_locked", locked_out, 1);

    // dc=255, then a flat-low line reported by timeout every 512 cycles
    v0 = vcnt; e0 = ecnt;
    pwm(255, 4 * P);
    chk("dc255_valids", vcnt - v0, 4);
    chk("dc255_dc", dc_out, 255);
    v0 = vcnt;
    pwm(0, 1100);
    chk("dc0_valids", vcnt - v0, 2);
    chk("dc0_dc", dc_out, 0);
    chk("dc0_locked", locked_out, 0);
    chk("dc0_errs", ecnt - e0, 0);

    // constant high from reset
    async_reset(3);
    v0 = vcnt;
    pwm(P, 1100);
    chk("hi_valids", vcnt - v0, 2);
    chk("hi_dc", dc_out, 255);
    chk("hi_locked", locked_out, 0);

    // 200-cycle square wave: errors only, dc_out untouched
    v0 = vcnt; e0 = ecnt;
    for (int k = 0; k < 5; k++) begin
      frame_raw(100, 0);
      frame_raw(100, 100);
    end
    chk("sq_errs", ecnt - e0, 4);
    chk("sq_valids", vcnt - v0, 0);
    chk("sq_dc", dc_out, 255);
    chk("sq_locked", locked_out, 0);

    // lock on dc=64, reset mid-frame, relock at the second rise
    ph = 0;
    pwm(64, 4 * P);
    chk("dc64_locked", locked_out, 1);
    chk("dc64_dc", dc_out, 64);
    pwm(64, 100);
    async_reset(3);
    v0 = vcnt; e0 = ecnt;
    pwm(64, ((P - ph) % P) + P);
    chk("rst_relock_early", vcnt - v0, 0);
    pwm(64, 10);
    chk("rst_relock_valids", vcnt - v0, 1);
    chk("rst_relock_dc", dc_out, 64);
    chk("rst_relock_errs", ecnt - e0, 0);

    // enable low for 1000 cycles while locked
    pwm(64, (100 - ph + P) % P);
    chk("en_pre_locked", locked_out, 1);
    en_in = 1'b0;
    v0 = vcnt; e0 = ecnt;
    pwm(64, 1000);
    chk("en_off_valids", vcnt - v0, 0);
    chk("en_off_errs", ecnt - e0, 0);
    chk("en_off_locked", locked_out, 0);
    chk("en_off_dc", dc_out, 64);
    en_in = 1'b1;
    v0 = vcnt;
    pwm(64, ((P - ph) % P) + P);
    chk("en_on_early", vcnt - v0, 0);
    pwm(64, 10);
    chk("en_on_valids", vcnt - v0, 1);
    chk("en_on_dc", dc_out, 64);

    // random duty cycles on exact frames
    pwm(64, (P - ph) % P);
    for (int k = 0; k < 8; k++) pwm(int'($urandom_range(1, 255)), P);

    // random frame lengths, enable glitches and a long flat line
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 4) == 0) begin
        en_in = 1'b0;
        frame_raw(int'($urandom_range(1, 30)), 0);
        en_in = 1'b1;
      end
      len = ($urandom_range(0, 2) == 0) ? P : int'($urandom_range(150, 400));
      hi  = int'($urandom_range(1, len - 1));
      frame_raw(len, hi);
    end
    lvl = int'($urandom_range(0, 1));
    frame_raw(1200, (lvl != 0) ? 1200 : 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
